// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter.
//   arb_state_e     : arbiter FSM states
//   *_DEF           : default parameter values for the top level
//   clog2()         : ceiling log2, usable in constant expressions
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ISSUE    = 3'd2,
        BURST    = 3'd3,
        DONE     = 3'd4
    } arb_state_e;

    localparam int unsigned BURST_LEN_DEF   = 8;
    localparam int unsigned ADR_W_DEF       = 25;
    localparam int unsigned DAT_W_DEF       = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 1023;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req_i  : request vector, bit N = client N
//   last_i : client served most recently
//   any_o  : at least one request present
//   pick_o : chosen client (valid when any_o)
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       any_o,
    output logic       pick_o
);

    always_comb begin
        any_o = |req_i;
        // On contention favour the client not served last; otherwise the lone requester.
        if (&req_i) pick_o = ~last_i;
        else        pick_o = req_i[1];
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Shares one SDRAM controller burst port between two clients.
//   clk, rst                  : clock, async active-high reset
//   cN_req/we/adr/wdata       : client N burst request, direction, start address, write data
//   cN_gnt/beat/rdata         : client N grant, beat strobe, read data
//   ready                     : controller accepts a new burst
//   wr_req/rd_req/adr_sdram   : burst command to the controller
//   data_to_sdram             : write data (mux of the granted client)
//   data_from_sdram, wr_valid, rd_valid : controller beat handshakes
//   busy, err_timeout         : status, one-cycle abort pulse
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
    parameter int unsigned ADR_W       = ADR_W_DEF,
    parameter int unsigned DAT_W       = DAT_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c0_req,
    input  logic             c0_we,
    input  logic [ADR_W-1:0] c0_adr,
    input  logic [DAT_W-1:0] c0_wdata,
    output logic             c0_gnt,
    output logic             c0_beat,
    output logic [DAT_W-1:0] c0_rdata,
    input  logic             c1_req,
    input  logic             c1_we,
    input  logic [ADR_W-1:0] c1_adr,
    input  logic [DAT_W-1:0] c1_wdata,
    output logic             c1_gnt,
    output logic             c1_beat,
    output logic [DAT_W-1:0] c1_rdata,
    input  logic             ready,
    output logic             wr_req,
    output logic             rd_req,
    output logic [ADR_W-1:0] adr_sdram,
    output logic [DAT_W-1:0] data_to_sdram,
    input  logic [DAT_W-1:0] data_from_sdram,
    input  logic             wr_valid,
    input  logic             rd_valid,
    output logic             busy,
    output logic             err_timeout
);

    localparam int unsigned BCW = clog2(BURST_LEN) + 1;
    localparam int unsigned TCW = clog2(TIMEOUT_CYC + 1);
    localparam logic [ADR_W-1:0] ADR_MASK = ~ADR_W'(BURST_LEN - 1);

    arb_state_e state_q, state_d;

    logic             sel_q, sel_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             gnt_q, gnt_d;
    logic             wr_req_q, wr_req_d;
    logic             rd_req_q, rd_req_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TCW-1:0]   to_cnt_q, to_cnt_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             rbeat_q, rbeat_d;
    logic [DAT_W-1:0] rdata0_q, rdata0_d;
    logic [DAT_W-1:0] rdata1_q, rdata1_d;

    logic arb_any, arb_pick;
    logic active, beat, last_beat, timeout;

    rr_arb2 u_arb (
        .req_i  ({c1_req, c0_req}),
        .last_i (last_q),
        .any_o  (arb_any),
        .pick_o (arb_pick)
    );

    // Only beats of the granted direction, while a command is outstanding, count.
    assign active    = (state_q == ISSUE) || (state_q == BURST);
    assign beat      = active && (we_q ? wr_valid : rd_valid);
    assign last_beat = (state_q == ISSUE) ? (BURST_LEN == 1)
                                          : (beat_cnt_q == BCW'(BURST_LEN - 1));
    // A beat in the same cycle wins over the timeout.
    assign timeout   = active && !beat && (to_cnt_q == TCW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (arb_any) state_d = WAIT_RDY;
            WAIT_RDY: if (ready)   state_d = ISSUE;
            ISSUE, BURST: begin
                if (beat)         state_d = last_beat ? DONE : BURST;
                else if (timeout) state_d = IDLE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d      = sel_q;
        we_d       = we_q;
        adr_d      = adr_q;
        gnt_d      = gnt_q;
        wr_req_d   = wr_req_q;
        rd_req_d   = rd_req_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        last_d     = last_q;
        err_d      = 1'b0;
        rbeat_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    sel_d      = arb_pick;
                    we_d       = arb_pick ? c1_we : c0_we;
                    adr_d      = (arb_pick ? c1_adr : c0_adr) & ADR_MASK;
                    gnt_d      = 1'b1;
                    beat_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            WAIT_RDY: begin
                if (ready) begin
                    wr_req_d = we_q;
                    rd_req_d = ~we_q;
                end
            end
            ISSUE, BURST: begin
                if (beat) begin
                    wr_req_d   = 1'b0;
                    rd_req_d   = 1'b0;
                    to_cnt_d   = '0;
                    beat_cnt_d = (state_q == ISSUE) ? BCW'(1) : beat_cnt_q + BCW'(1);
                    // Grant drops as DONE is entered so it is already low in DONE.
                    if (last_beat) gnt_d = 1'b0;
                    if (!we_q) begin
                        rbeat_d = 1'b1;
                        if (sel_q) rdata1_d = data_from_sdram;
                        else       rdata0_d = data_from_sdram;
                    end
                end else if (timeout) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    gnt_d    = 1'b0;
                    err_d    = 1'b1;
                    last_d   = sel_q;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
            end
            DONE: begin
                last_d     = sel_q;
                beat_cnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            gnt_q      <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
            rbeat_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            sel_q      <= sel_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            gnt_q      <= gnt_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            last_q     <= last_d;
            err_q      <= err_d;
            rbeat_q    <= rbeat_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Write beats strobe combinationally; read beats strobe with the registered data.
    assign c0_gnt        = gnt_q & ~sel_q;
    assign c1_gnt        = gnt_q &  sel_q;
    assign c0_beat       = ~sel_q & ((beat & we_q) | rbeat_q);
    assign c1_beat       =  sel_q & ((beat & we_q) | rbeat_q);
    assign c0_rdata      = rdata0_q;
    assign c1_rdata      = rdata1_q;
    assign wr_req        = wr_req_q;
    assign rd_req        = rd_req_q;
    assign adr_sdram     = adr_q;
    assign data_to_sdram = sel_q ? c1_wdata : c0_wdata;
    assign busy          = (state_q != IDLE);
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed self-checking bench for sdram_burst_arbiter (default parameters).
module tb_sdram_burst_arbiter;

    logic        clk, rst;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [24:0] c0_adr, c1_adr;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c0_beat, c1_gnt, c1_beat;
    logic [15:0] c0_rdata, c1_rdata;
    logic        ready, wr_req, rd_req;
    logic [24:0] adr_sdram;
    logic [15:0] data_to_sdram, data_from_sdram;
    logic        wr_valid, rd_valid, busy, err_timeout;

    int total = 0;
    int bad   = 0;

    sdram_burst_arbiter #(
        .BURST_LEN   (8),
        .ADR_W       (25),
        .DAT_W       (16),
        .TIMEOUT_CYC (1023)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .c0_req          (c0_req),
        .c0_we           (c0_we),
        .c0_adr          (c0_adr),
        .c0_wdata        (c0_wdata),
        .c0_gnt          (c0_gnt),
        .c0_beat         (c0_beat),
        .c0_rdata        (c0_rdata),
        .c1_req          (c1_req),
        .c1_we           (c1_we),
        .c1_adr          (c1_adr),
        .c1_wdata        (c1_wdata),
        .c1_gnt          (c1_gnt),
        .c1_beat         (c1_beat),
        .c1_rdata        (c1_rdata),
        .ready           (ready),
        .wr_req          (wr_req),
        .rd_req          (rd_req),
        .adr_sdram       (adr_sdram),
        .data_to_sdram   (data_to_sdram),
        .data_from_sdram (data_from_sdram),
        .wr_valid        (wr_valid),
        .rd_valid        (rd_valid),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int beats, ngr, idle, pulses, first_pulse, n;
        logic prev0, prev1, done;
        logic order [8];

        rst = 1'b1;
        c0_req = 0; c0_we = 0; c0_adr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_adr = '0; c1_wdata = '0;
        ready = 0; wr_valid = 0; rd_valid = 0; data_from_sdram = '0;
        #1;
        chk("rst_c0_gnt", 32'(c0_gnt), 32'd0);
        chk("rst_c1_gnt", 32'(c1_gnt), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_err",    32'(err_timeout), 32'd0);
        chk("rst_adr",    32'(adr_sdram),   32'd0);
        chk("rst_rdata0", 32'(c0_rdata),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        // c0 write burst, address low bits masked, 8 combinational beats
        c0_req = 1; c0_we = 1; c0_adr = 25'h0000123; ready = 1; c0_wdata = 16'hA000;
        tick(); #1;
        chk("wr_c0_gnt", 32'(c0_gnt), 32'd1);
        chk("wr_busy",   32'(busy),   32'd1);
        chk("wr_adr",    32'(adr_sdram), 32'h0000120);
        chk("wr_req_wait", 32'(wr_req), 32'd0);
        c0_req = 0;
        tick(); #1;
        chk("wr_req_issue", 32'(wr_req), 32'd1);
        chk("wr_rd_req_low", 32'(rd_req), 32'd0);
        wr_valid = 1;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (c0_beat === 1'b1) beats++;
            chk("wr_data_mux", 32'(data_to_sdram), 32'(16'hA000 + i));
            chk("wr_c1_beat", 32'(c1_beat), 32'd0);
            tick();
            if (i == 0) chk("wr_req_drop", 32'(wr_req), 32'd0);
            c0_wdata = 16'(16'hA000 + i + 1);
        end
        #1;
        chk("wr_beats", 32'(beats), 32'd8);
        chk("wr_done_gnt", 32'(c0_gnt), 32'd0);
        chk("wr_done_busy", 32'(busy), 32'd1);
        chk("wr_done_nobeat", 32'(c0_beat), 32'd0);
        wr_valid = 0;
        tick(); #1;
        chk("wr_idle_busy", 32'(busy), 32'd0);
        chk("wr_idle_adr_hold", 32'(adr_sdram), 32'h0000120);

        // c1 read burst, rdata registered with one-cycle latency
        c1_req = 1; c1_we = 0; c1_adr = 25'h0ABCDEF;
        tick(); #1;
        chk("rd_c1_gnt", 32'(c1_gnt), 32'd1);
        chk("rd_c0_gnt", 32'(c0_gnt), 32'd0);
        chk("rd_adr", 32'(adr_sdram), 32'h0ABCDE8);
        c1_req = 0;
        tick(); #1;
        chk("rd_req_issue", 32'(rd_req), 32'd1);
        chk("rd_wr_req_low", 32'(wr_req), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            data_from_sdram = 16'(i);
            rd_valid = 1;
            #1;
            if (i == 1) chk("rd_no_early_beat", 32'(c1_beat), 32'd0);
            tick(); #1;
            chk("rd_c1_beat", 32'(c1_beat), 32'd1);
            chk("rd_c1_rdata", 32'(c1_rdata), 32'(i));
            chk("rd_c0_beat", 32'(c0_beat), 32'd0);
            chk("rd_c0_rdata", 32'(c0_rdata), 32'd0);
            if (i == 1) chk("rd_req_drop", 32'(rd_req), 32'd0);
            if (i == 8) begin
                chk("rd_done_gnt", 32'(c1_gnt), 32'd0);
                chk("rd_done_busy", 32'(busy), 32'd1);
            end
        end
        rd_valid = 0;
        tick(); #1;
        chk("rd_idle_beat", 32'(c1_beat), 32'd0);
        chk("rd_idle_busy", 32'(busy), 32'd0);

        // Both requesting: alternate grants starting with c0, one idle cycle between bursts
        c0_req = 1; c1_req = 1; c0_we = 1; c1_we = 1; ready = 1; wr_valid = 1;
        prev0 = 0; prev1 = 0; ngr = 0; idle = 0;
        for (int k = 0; k < 80 && ngr < 4; k++) begin
            tick(); #1;
            if (c0_gnt === 1'b1 && !prev0) begin order[ngr] = 1'b0; ngr++; end
            if (c1_gnt === 1'b1 && !prev1) begin order[ngr] = 1'b1; ngr++; end
            if (ngr > 0 && ngr < 4 && busy === 1'b0) idle++;
            prev0 = c0_gnt;
            prev1 = c1_gnt;
        end
        chk("rr_grants", 32'(ngr), 32'd4);
        if (ngr == 4) begin
            chk("rr_order0", 32'(order[0]), 32'd0);
            chk("rr_order1", 32'(order[1]), 32'd1);
            chk("rr_order2", 32'(order[2]), 32'd0);
            chk("rr_order3", 32'(order[3]), 32'd1);
        end
        chk("rr_idle_cycles", 32'(idle), 32'd3);
        c0_req = 0; c1_req = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick(); #1;
            if (busy === 1'b0) done = 1;
        end
        chk("rr_drain", 32'(done), 32'd1);
        wr_valid = 0;

        // c0 read with no rd_valid: abort after the to_cnt limit is reached
        c0_req = 1; c0_we = 0; c0_adr = 25'h0000040;
        tick(); c0_req = 0;
        tick(); #1;
        chk("to_rd_req", 32'(rd_req), 32'd1);
        pulses = 0; first_pulse = 0;
        for (n = 1; n <= 1100; n++) begin
            tick(); #1;
            if (err_timeout === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_pulse = n;
                    chk("to_rd_req_low", 32'(rd_req), 32'd0);
                    chk("to_gnt_low", 32'(c0_gnt), 32'd0);
                    chk("to_idle", 32'(busy), 32'd0);
                end
            end
        end
        chk("to_pulses", 32'(pulses), 32'd1);
        // ISSUE entered with to_cnt=0; it reaches 1023 after 1023 edges, abort registers on the next
        chk("to_latency", 32'(first_pulse), 32'd1024);
        c0_req = 1; c1_req = 1; c0_we = 1; c1_we = 1;
        tick(); #1;
        chk("to_next_c1", 32'(c1_gnt), 32'd1);
        chk("to_next_c0", 32'(c0_gnt), 32'd0);
        c0_req = 0; c1_req = 0; ready = 1; wr_valid = 1;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick(); #1;
            if (busy === 1'b0) done = 1;
        end
        chk("to_drain", 32'(done), 32'd1);
        wr_valid = 0;

        // Wrong-direction valids ignored; valids in WAIT_RDY ignored
        c0_req = 1; c0_we = 1; c0_adr = 25'h1FFFFFF; ready = 0;
        tick(); #1;
        chk("wd_adr_top", 32'(adr_sdram), 32'h1FFFFF8);
        c0_req = 0; wr_valid = 1; rd_valid = 1; data_from_sdram = 16'hDEAD;
        #1;
        chk("wd_wait_nobeat", 32'(c0_beat), 32'd0);
        tick(); #1;
        chk("wd_wait_noreq", 32'(wr_req), 32'd0);
        chk("wd_wait_gnt", 32'(c0_gnt), 32'd1);
        ready = 1; wr_valid = 0; rd_valid = 0;
        tick(); #1;
        chk("wd_req", 32'(wr_req), 32'd1);
        beats = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            wr_valid = (k % 2 == 0);
            rd_valid = (k % 2 != 0);
            #1;
            if (c0_beat === 1'b1) beats++;
            tick(); #1;
            if (c0_gnt === 1'b0) done = 1;
        end
        wr_valid = 0; rd_valid = 0;
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_beats", 32'(beats), 32'd8);
        chk("wd_c0_rdata", 32'(c0_rdata), 32'd0);
        chk("wd_c1_rdata", 32'(c1_rdata), 32'd8);
        tick();

        // Reset mid-burst, then c0 wins first again
        c0_req = 1; c0_we = 1; c0_adr = 25'h0000100; ready = 1;
        tick(); c0_req = 0;
        tick();
        wr_valid = 1;
        for (int k = 0; k < 4; k++) tick();
        rst = 1;
        #1;
        chk("mr_gnt", 32'(c0_gnt), 32'd0);
        chk("mr_wr_req", 32'(wr_req), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_adr", 32'(adr_sdram), 32'd0);
        chk("mr_beat", 32'(c0_beat), 32'd0);
        chk("mr_c1_rdata", 32'(c1_rdata), 32'd0);
        c0_req = 1; c1_req = 1; wr_valid = 0;
        tick();
        rst = 0;
        tick(); #1;
        chk("mr_first_c0", 32'(c0_gnt), 32'd1);
        chk("mr_first_c1", 32'(c1_gnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
